// File: rtl/ahb_uart_regif.sv
// AHB-Lite register slave in front of the UART core: UBRR/UCR control, TX push, RX pop, UFR flags.
// Optional interrupt block (IER/ISR/IRQ) is built only when AHB_UART_IRQ_EN is defined.
module ahb_uart_regif #(
  parameter logic [15:0] UBRR_RST = 16'd0,
  parameter logic [7:0]  UCR_RST  = 8'h00
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [15:0] UBRR,
  output logic [7:0]  UCR,
  input  logic [7:0]  UFR,
  output logic [7:0]  TX_DIN,
  output logic        write_fifo,
  input  logic [7:0]  RX_DOUT,
  output logic        read_fifo,
  output logic        IRQ
);

  localparam logic [2:0] IDX_DATA = 3'd0;
  localparam logic [2:0] IDX_UBRR = 3'd1;
  localparam logic [2:0] IDX_UCR  = 3'd2;
  localparam logic [2:0] IDX_UFR  = 3'd3;
  localparam logic [2:0] IDX_IER  = 3'd4;
  localparam logic [2:0] IDX_ISR  = 3'd5;

  typedef enum logic [1:0] {OKAY_ST, ERR1, ERR2} rsp_t;

  rsp_t       state_q, state_d, rsp_now;
  logic       dp_valid, dp_write;
  logic [2:0] dp_idx;
  logic       addr_ok, dp_data_wr, dp_data_rd, ok_phase, reg_wr;
  logic       tx_full, rx_empty;

  assign addr_ok  = HSEL & HTRANS[1] & HREADY;
  assign tx_full  = UFR[3];
  assign rx_empty = UFR[6];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
    end else begin
      dp_valid <= addr_ok;
      if (addr_ok) begin
        dp_write <= HWRITE;
        dp_idx   <= HADDR[4:2];
      end
    end
  end

  assign dp_data_wr = dp_valid & dp_write & (dp_idx == IDX_DATA);
  assign dp_data_rd = dp_valid & ~dp_write & (dp_idx == IDX_DATA);

  // ERR1 is the first cycle of the offending data phase, so it is decoded
  // combinationally from live UFR[3]; only ERR2 is ever held in the register.
  always_comb begin
    rsp_now = state_q;
    if (state_q == OKAY_ST && dp_data_wr && tx_full)
      rsp_now = ERR1;
  end

  always_comb begin
    state_d = OKAY_ST;
    case (rsp_now)
      OKAY_ST: state_d = OKAY_ST;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = OKAY_ST;
      default: state_d = OKAY_ST;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= OKAY_ST;
    else         state_q <= state_d;
  end

  assign HREADYOUT  = (rsp_now != ERR1);
  assign HRESP      = (rsp_now != OKAY_ST);
  assign ok_phase   = (rsp_now == OKAY_ST);
  assign reg_wr     = dp_valid & dp_write & ok_phase;

  assign write_fifo = dp_data_wr & ok_phase;
  assign TX_DIN     = dp_data_wr ? HWDATA[7:0] : '0;
  assign read_fifo  = dp_data_rd & ~rx_empty & ok_phase;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      UBRR <= UBRR_RST;
      UCR  <= UCR_RST;
    end else if (reg_wr) begin
      if (dp_idx == IDX_UBRR) UBRR <= HWDATA[15:0];
      if (dp_idx == IDX_UCR)  UCR  <= HWDATA[7:0];
    end
  end

`ifdef AHB_UART_IRQ_EN
  logic [2:0] ier_q, isr_q, evt_prev_q, evt_now, evt_rise, isr_clr;

  // Event order matches ISR bit order: RX data available, TX empty, RX error.
  assign evt_now  = {UFR[2], UFR[4], ~UFR[6]};
  assign evt_rise = evt_now & ~evt_prev_q;
  assign isr_clr  = (reg_wr && dp_idx == IDX_ISR) ? HWDATA[2:0] : '0;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ier_q      <= '0;
      isr_q      <= '0;
      evt_prev_q <= 3'b010;
      IRQ        <= 1'b0;
    end else begin
      evt_prev_q <= evt_now;
      if (reg_wr && dp_idx == IDX_IER) ier_q <= HWDATA[2:0];
      isr_q      <= (isr_q & ~isr_clr) | evt_rise;
      IRQ        <= |(isr_q & ier_q);
    end
  end
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_idx)
        IDX_DATA: HRDATA = rx_empty ? '0 : {24'b0, RX_DOUT};
        IDX_UBRR: HRDATA = {16'b0, UBRR};
        IDX_UCR:  HRDATA = {24'b0, UCR};
        IDX_UFR:  HRDATA = {24'b0, UFR};
`ifdef AHB_UART_IRQ_EN
        IDX_IER:  HRDATA = {29'b0, ier_q};
        IDX_ISR:  HRDATA = {29'b0, isr_q};
`endif
        default:  HRDATA = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:16], UFR,
                         IDX_IER, IDX_ISR};

endmodule

// File: doc/ahb_uart_regif.md
# ahb_uart_regif

AHB-Lite slave that sits directly upstream of the UART core and gives a bus master register-mapped access to it. It decodes AHB transfers into the core's control inputs (UBRR, UCR), its TX FIFO push (TX_DIN/write_fifo) and RX FIFO pop (RX_DOUT/read_fifo), and returns the flag register UFR. It also produces AHB error responses for TX overflow and an optional interrupt line.

## Interface
- UBRR_RST, 16'd0, reset value of the UBRR register
- UCR_RST, 8'h00, reset value of the UCR register
- CLK  in  1  system clock; all logic on posedge
- RESETN  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address; only [4:2] decoded
- HTRANS  in  2  transfer type; NONSEQ/SEQ (bit 1 set) are valid
- HWRITE  in  1  1 = write
- HSIZE  in  3  ignored; all accesses treated as 32-bit
- HREADY  in  1  bus-level ready
- HWDATA  in  32  write data, valid in data phase
- HRDATA  out  32  read data, valid in data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- UBRR  out  16  baud divisor to core
- UCR  out  8  control register to core
- UFR  in  8  core flags: [0] TX_DONE, [1] RX_DONE, [2] RX_ERR, [3] TX full, [4] TX empty, [5] RX full, [6] RX empty
- TX_DIN  out  8  byte to TX FIFO
- write_fifo  out  1  TX FIFO push strobe
- RX_DOUT  in  8  RX FIFO head (first-word fall-through)
- read_fifo  out  1  RX FIFO pop strobe
- IRQ  out  1  interrupt, registered (only with AHB_UART_IRQ_EN)

## Operation
- Address phase accepted when HSEL & HTRANS[1] & HREADY; registers valid, write, index = HADDR[4:2] into data-phase stage. Otherwise data-phase valid cleared.
- Map (index): 0 DATA, 1 UBRR (bits [15:0]), 2 UCR (bits [7:0]), 3 UFR (read-only), 4 IER, 5 ISR (4/5 only with macro). Unused bits read 0.
- DATA write: in data phase, if UFR[3]=0 → write_fifo=1 combinationally, TX_DIN=HWDATA[7:0], OKAY. If UFR[3]=1 → no push, two-cycle ERROR.
- DATA read: HRDATA={24'b0,RX_DOUT}; read_fifo=1 in that data phase if UFR[6]=0. If empty → HRDATA=0, no pop, OKAY.
- UBRR/UCR writes update on the clock edge ending the data phase; reads return current value. UFR writes ignored. Unmapped indices: read 0, write ignored, OKAY.
- Response FSM: OKAY_ST (HREADYOUT=1,HRESP=0) → on DATA write while full → ERR1 (HREADYOUT=0,HRESP=1) → ERR2 (HREADYOUT=1,HRESP=1) → OKAY_ST. Address phase presented during ERR2 is accepted normally.

## Timing
- Reset: HRDATA=0, HREADYOUT=1, HRESP=0, UBRR=UBRR_RST, UCR=UCR_RST, TX_DIN=0, write_fifo=0, read_fifo=0, IRQ=0, FSM=OKAY_ST, data-phase valid=0.
- Zero wait states on all OKAY transfers; HRDATA and strobes combinational from data-phase registers and UFR.
- write_fifo/read_fifo are single-cycle, asserted only in a data phase with HREADYOUT=1 (never in ERR1/ERR2).
- Back-to-back DATA writes: full checked each data phase from live UFR[3], so the FIFO flag updated by the previous push is honoured.
- Write and read of same register in consecutive transfers: read returns the newly written value.
- RESETN low mid-transfer: all state returns to reset values immediately; in-flight transfer is dropped.

## Configuration
- AHB_UART_IRQ_EN defined: IER (bits [2:0]) and ISR (bits [2:0], write-1-to-clear) exist. ISR[0] set on rising edge of !UFR[6] (RX data), ISR[1] on rising edge of UFR[4] (TX empty), ISR[2] on rising edge of UFR[2] (RX error). Set beats simultaneous clear. IRQ = registered |(ISR & IER).
- Undefined: indices 4/5 are unmapped (read 0), no edge detectors, IRQ tied 0.

## Test plan
- Reset, read UBRR/UCR/UFR → UBRR_RST, UCR_RST, live UFR; HRESP=0, HREADYOUT=1 throughout.
- Write UBRR=0x0145, UCR=0x2D, read back → 0x00000145, 0x0000002D; UBRR/UCR outputs change the cycle after the data phase.
- UFR[3]=0, write DATA=0xA5 → one-cycle write_fifo with TX_DIN=0xA5; with UFR[3]=1 → no write_fifo, HREADYOUT 0 then 1 with HRESP=1 both cycles.
- RX_DOUT=0x3C, UFR[6]=0, read DATA → HRDATA=0x3C, one read_fifo pulse; UFR[6]=1 → HRDATA=0, no pulse.
- Eight back-to-back DATA writes with a model FIFO (depth 8) then a ninth → eight pushes, ninth ERROR.
- With AHB_UART_IRQ_EN: IER=0x1, drive UFR[6] 1→0 → ISR=0x1, IRQ=1 next cycle; write ISR=0x1 → ISR=0, IRQ=0.
